lsu_align: RTL and testbench
============================

Name: lsu_align

Overview:
- Load/store alignment unit directly upstream of the word-organised, byte-enabled data memory.
- Converts a RISC-V byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW request into memory address, write enable, byte enables and lane-replicated write data.
- Waits out the memory's registered read latency, then returns the sign- or zero-extended load result.
- Flags misaligned, out-of-range and illegal-funct3 accesses without touching memory.

Parameters:
- MEMORY_SIZE, 12288, data memory size in bytes.
- ADDR_WIDTH, $clog2(MEMORY_SIZE), byte-address width presented to memory.
- READ_LATENCY, 2, clock edges from the address-accept edge to valid mem_rdata; legal range 1..3.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, taken from rs2.
- req_ready  out  1  unit idle; the request is accepted when req_valid and req_ready are both high.
- mem_addr  out  ADDR_WIDTH  byte address, req_addr[ADDR_WIDTH-1:0].
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read strobe.
- mem_byteena  out  4  byte-lane enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read word.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  access fault, qualified by resp_valid.

Behaviour:
- States: IDLE, WAIT, RESP. req_ready = (state == IDLE).
- Reset values: state = IDLE, wait counter = 0, resp_valid = 0, resp_rdata = 0, resp_fault = 0.
- Memory outputs are combinational and active only in the accept cycle. In every other cycle mem_we = 0, mem_re = 0 and mem_byteena = 0.
- Fault conditions, evaluated in the accept cycle:
  - req_addr >= MEMORY_SIZE.
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 >= 011.
- On a fault: no memory strobe, next state RESP, resp_fault = 1, resp_rdata = 0.
- Byte offset is off = addr[1:0].
- Store lane mapping:
  - SB: byteena = 0001 << off; wdata = {4{wdata[7:0]}}.
  - SH: byteena = 0011 << off; wdata = {2{wdata[15:0]}}.
  - SW: byteena = 1111; wdata passed through.
- Accepted store: mem_we = 1 for exactly one cycle, then IDLE -> RESP. resp_valid rises on the following cycle with resp_rdata = 0. Store latency is 1 cycle.
- Accepted load: mem_re = 1. Latch funct3 and off. IDLE -> WAIT with counter = READ_LATENCY - 1.
- In WAIT, decrement the counter each cycle. When the counter is 0, mem_rdata is valid. On that edge:
  - Register the extracted result: shifted = mem_rdata >> (8 * off).
  - LB/LBU sign- or zero-extend shifted[7:0]; LH/LHU extend shifted[15:0]; LW passes the full word.
  - Go to RESP.
- Load latency: resp_valid is high in cycle T + READ_LATENCY + 1, where T is the accept cycle. With the default this is T + 3.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. req_ready is low throughout WAIT and RESP.
- A new request can be accepted in the cycle after RESP. Issue is never back-to-back.
- req_valid while req_ready = 0 is ignored. The requester holds the request until it is accepted.
- rst asserted mid-WAIT or in RESP: the cycle after, state = IDLE and resp_valid = 0. The in-flight load is discarded and no response is produced. The memory read already issued is harmless.
- resp_rdata and resp_fault hold their last values outside resp_valid. Consumers use them only when resp_valid = 1.

Test Plan:
- Reset, then SW addr 0x0010, wdata 0xDEADBEEF -> accept cycle shows mem_we = 1, byteena = 1111, mem_wdata = 0xDEADBEEF. resp_valid in the next cycle with fault = 0.
- SB addr 0x0013, wdata 0x000000A5 -> byteena = 1000, mem_wdata = 0xA5A5A5A5. SH addr 0x0012, wdata 0x1234 -> byteena = 1100, mem_wdata = 0x12341234.
- Memory model word at 0x0010 = 0x80FF7F01:
  - LB off 1 -> 0x0000007F.
  - LB off 2 -> 0xFFFFFFFF.
  - LBU off 3 -> 0x00000080.
  - LH off 2 -> 0xFFFF80FF.
  - LHU off 0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
  - Each result has resp_valid exactly 3 cycles after accept.
- LW addr 0x0012, SH addr 0x0011, LB addr 0x3000 and load funct3 = 011 -> each gives mem_we = 0, mem_re = 0, byteena = 0. resp_valid the next cycle with resp_fault = 1, resp_rdata = 0.
- Load accepted, rst asserted the cycle after -> no resp_valid ever appears for that load, and req_ready = 1 the cycle after reset. A following LW completes normally.
- req_valid held high continuously with alternating loads and stores -> req_ready low in WAIT/RESP, and exactly one memory strobe per accepted request. Repeat with READ_LATENCY = 1 and 3, expecting load latency of 2 and 4 cycles.

Source files
------------

// File: rtl/lsu_align.sv
// Load/store alignment unit sitting in front of a word-organised, byte-enabled data memory.
// Maps RV32I loads/stores onto lanes, waits out the read latency and extends the load result.
module lsu_align #(
    parameter int MEMORY_SIZE  = 12288,
    parameter int ADDR_WIDTH   = $clog2(MEMORY_SIZE),
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [3:0]            mem_byteena,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

    logic [1:0]  state;
    logic [1:0]  wait_cnt;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_off;
    logic [1:0]  off;
    logic        accept;
    logic        out_of_range;
    logic        misaligned;
    logic        illegal;
    logic        fault;
    logic [31:0] shifted;
    logic [31:0] load_result;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign off       = req_addr[1:0];
    assign mem_addr  = req_addr[ADDR_WIDTH-1:0];

    // funct3[1:0] encodes access size for both loads and stores; funct3[2] is the unsigned bit for loads.
    always_comb begin
        out_of_range = (req_addr >= 32'(MEMORY_SIZE));
        misaligned   = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        if (req_we)
            illegal = (req_funct3 >= 3'b011);
        else
            illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        fault = out_of_range || misaligned || illegal;
    end

    always_comb begin
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_byteena = 4'b0000;
        case (req_funct3[1:0])
            2'b00:   mem_wdata = {4{req_wdata[7:0]}};
            2'b01:   mem_wdata = {2{req_wdata[15:0]}};
            default: mem_wdata = req_wdata;
        endcase
        if (accept && !fault) begin
            if (req_we) begin
                mem_we = 1'b1;
                case (req_funct3[1:0])
                    2'b00:   mem_byteena = 4'b0001 << off;
                    2'b01:   mem_byteena = 4'b0011 << off;
                    default: mem_byteena = 4'b1111;
                endcase
            end else begin
                mem_re = 1'b1;
            end
        end
    end

    always_comb begin
        shifted = mem_rdata >> {ld_off, 3'b000};
        case (ld_funct3)
            3'b000:  load_result = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_result = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_result = {24'h000000, shifted[7:0]};
            3'b101:  load_result = {16'h0000, shifted[15:0]};
            default: load_result = shifted;
        endcase
    end

    // resp_valid is set on every entry into RESP and cleared on leaving it, so it mirrors that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= 2'd0;
            ld_funct3  <= 3'b000;
            ld_off     <= 2'b00;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_fault <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (fault || req_we) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= fault;
                            resp_rdata <= 32'h0;
                        end else begin
                            state     <= S_WAIT;
                            ld_funct3 <= req_funct3;
                            ld_off    <= off;
                            wait_cnt  <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= load_result;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align: three instances (READ_LATENCY 2, 1, 3) each backed by a
// registered read-only memory model whose data is only valid READ_LATENCY edges after mem_re.
module tb_lsu_align;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [3];
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready [3];
    logic [13:0] mem_addr [3];
    logic        mem_we [3];
    logic        mem_re [3];
    logic [3:0]  mem_byteena [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];
    logic        resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic        resp_fault [3];
    logic [31:0] mem_words [16];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
        logic [31:0] pipe [3];

        lsu_align #(.READ_LATENCY(LAT)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .req_valid   (req_valid[g]),
            .req_we      (req_we),
            .req_funct3  (req_funct3),
            .req_addr    (req_addr),
            .req_wdata   (req_wdata),
            .req_ready   (req_ready[g]),
            .mem_addr    (mem_addr[g]),
            .mem_we      (mem_we[g]),
            .mem_re      (mem_re[g]),
            .mem_byteena (mem_byteena[g]),
            .mem_wdata   (mem_wdata[g]),
            .mem_rdata   (mem_rdata[g]),
            .resp_valid  (resp_valid[g]),
            .resp_rdata  (resp_rdata[g]),
            .resp_fault  (resp_fault[g])
        );

        // Garbage fills the pipeline when no read was issued, so a wrong sampling edge shows up.
        always @(posedge clk) begin
            pipe[0] <= mem_re[g] ? mem_words[mem_addr[g][5:2]] : 32'h5A5A5A5A;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign mem_rdata[g] = pipe[LAT-1];
    end

    function automatic int lat_of(input int idx);
        return (idx == 0) ? 2 : ((idx == 1) ? 1 : 3);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request to instance idx, checks the accept-cycle memory strobes, then
    // follows it to its response. With hold set, req_valid stays high after acceptance.
    task automatic applyStimulus(input int idx, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic exp_fault, input logic [31:0] exp_rdata,
                                 input logic [3:0] exp_be, input logic [31:0] exp_wd,
                                 input bit hold);
        int          lat_exp;
        int          seen_lat;
        int          n;
        int          strobes;
        int          ready_hi;
        logic [31:0] got_rdata;
        logic        got_fault;
        string       t;
        t = $sformatf("d%0d %s f3=%0d a=%h", idx, we ? "ST" : "LD", f3, addr);
        lat_exp = (we || exp_fault) ? 1 : lat_of(idx) + 1;
        @(negedge clk);
        req_we         = we;
        req_funct3     = f3;
        req_addr       = addr;
        req_wdata      = wdata;
        req_valid[idx] = 1'b1;
        #1;
        checkOutput({t, " ready"}, 32'(req_ready[idx]), 32'd1);
        checkOutput({t, " mem_we"}, 32'(mem_we[idx]), 32'(we && !exp_fault));
        checkOutput({t, " mem_re"}, 32'(mem_re[idx]), 32'(!we && !exp_fault));
        checkOutput({t, " byteena"}, 32'(mem_byteena[idx]), 32'(exp_be));
        if (we && !exp_fault)
            checkOutput({t, " mem_wdata"}, mem_wdata[idx], exp_wd);
        if (!exp_fault)
            checkOutput({t, " mem_addr"}, 32'(mem_addr[idx]), {18'h0, addr[13:0]});
        @(posedge clk);
        #1;
        if (!hold)
            req_valid[idx] = 1'b0;
        seen_lat  = 0;
        strobes   = 0;
        ready_hi  = 0;
        n         = 0;
        got_rdata = 32'hx;
        got_fault = 1'bx;
        while (seen_lat == 0 && n < 10) begin
            @(negedge clk);
            n++;
            if (mem_we[idx] || mem_re[idx] || mem_byteena[idx] != 4'b0000)
                strobes++;
            if (req_ready[idx])
                ready_hi++;
            if (resp_valid[idx]) begin
                seen_lat  = n;
                got_rdata = resp_rdata[idx];
                got_fault = resp_fault[idx];
            end
        end
        checkOutput({t, " latency"}, 32'(seen_lat), 32'(lat_exp));
        checkOutput({t, " resp_rdata"}, got_rdata, exp_rdata);
        checkOutput({t, " resp_fault"}, 32'(got_fault), 32'(exp_fault));
        checkOutput({t, " extra strobes"}, 32'(strobes), 32'd0);
        checkOutput({t, " ready while busy"}, 32'(ready_hi), 32'd0);
    endtask

    initial begin
        int late_resp;
        rst        = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 3; i++)
            req_valid[i] = 1'b0;
        for (int i = 0; i < 16; i++)
            mem_words[i] = 32'h0;
        mem_words[4]  = 32'h80FF7F01;
        mem_words[15] = 32'h11223344;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("d%0d reset ready", i), 32'(req_ready[i]), 32'd1);
            checkOutput($sformatf("d%0d reset resp_valid", i), 32'(resp_valid[i]), 32'd0);
            checkOutput($sformatf("d%0d reset resp_rdata", i), resp_rdata[i], 32'h0);
            checkOutput($sformatf("d%0d reset resp_fault", i), 32'(resp_fault[i]), 32'd0);
        end

        $display("[TB] stores and lane mapping");
        applyStimulus(0, 1'b1, 3'b010, 32'h0010, 32'hDEADBEEF, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, 0);
        applyStimulus(0, 1'b1, 3'b000, 32'h0013, 32'h000000A5, 1'b0, 32'h0, 4'h8, 32'hA5A5A5A5, 0);
        applyStimulus(0, 1'b1, 3'b001, 32'h0012, 32'h00001234, 1'b0, 32'h0, 4'hC, 32'h12341234, 0);

        $display("[TB] loads with extension");
        applyStimulus(0, 1'b0, 3'b000, 32'h0011, 32'h0, 1'b0, 32'h0000007F, 4'h0, 32'h0, 0);
        applyStimulus(0, 1'b0, 3'b000, 32'h0012, 32'h0, 1'b0, 32'hFFFFFFFF, 4'h0, 32'h0, 0);
        applyStimulus(0, 1'b0, 3'b100, 32'h0013, 32'h0, 1'b0, 32'h00000080, 4'h0, 32'h0, 0);
        applyStimulus(0, 1'b0, 3'b001, 32'h0012, 32'h0, 1'b0, 32'hFFFF80FF, 4'h0, 32'h0, 0);
        applyStimulus(0, 1'b0, 3'b101, 32'h0010, 32'h0, 1'b0, 32'h00007F01, 4'h0, 32'h0, 0);
        applyStimulus(0, 1'b0, 3'b010, 32'h0010, 32'h0, 1'b0, 32'h80FF7F01, 4'h0, 32'h0, 0);
        applyStimulus(0, 1'b0, 3'b100, 32'h2FFF, 32'h0, 1'b0, 32'h00000011, 4'h0, 32'h0, 0);
        applyStimulus(0, 1'b0, 3'b001, 32'h2FFE, 32'h0, 1'b0, 32'h00001122, 4'h0, 32'h0, 0);

        $display("[TB] faulting accesses");
        applyStimulus(0, 1'b0, 3'b010, 32'h0012, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 0);
        applyStimulus(0, 1'b1, 3'b001, 32'h0011, 32'h0000BEEF, 1'b1, 32'h0, 4'h0, 32'h0, 0);
        applyStimulus(0, 1'b0, 3'b000, 32'h3000, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 0);
        applyStimulus(0, 1'b0, 3'b011, 32'h0010, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 0);
        applyStimulus(0, 1'b0, 3'b110, 32'h0010, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 0);
        applyStimulus(0, 1'b1, 3'b011, 32'h0010, 32'h12345678, 1'b1, 32'h0, 4'h0, 32'h0, 0);

        $display("[TB] reset during an in-flight load");
        @(negedge clk);
        req_we       = 1'b0;
        req_funct3   = 3'b010;
        req_addr     = 32'h0010;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset mid-wait ready", 32'(req_ready[0]), 32'd1);
        checkOutput("reset mid-wait resp_valid", 32'(resp_valid[0]), 32'd0);
        late_resp = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid[0])
                late_resp++;
        end
        checkOutput("discarded load responses", 32'(late_resp), 32'd0);
        applyStimulus(0, 1'b0, 3'b010, 32'h0010, 32'h0, 1'b0, 32'h80FF7F01, 4'h0, 32'h0, 0);

        $display("[TB] continuous req_valid, alternating loads and stores");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(i, 1'b0, 3'b010, 32'h0010, 32'h0, 1'b0, 32'h80FF7F01, 4'h0, 32'h0, 1);
            applyStimulus(i, 1'b1, 3'b010, 32'h0014, 32'hCAFEF00D, 1'b0, 32'h0, 4'hF, 32'hCAFEF00D, 1);
            applyStimulus(i, 1'b0, 3'b100, 32'h0011, 32'h0, 1'b0, 32'h0000007F, 4'h0, 32'h0, 1);
            applyStimulus(i, 1'b1, 3'b001, 32'h0012, 32'h0000BEEF, 1'b0, 32'h0, 4'hC, 32'hBEEFBEEF, 1);
            req_valid[i] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
